// File: rtl/main_stream_ctrl.sv
`default_nettype none
// ============================================================================
// main_stream_ctrl : job controller for NLANES lockstep streaming kernel lanes
//   Gates input and output vectors, counts beats and flags lane skew.
//   Optional STALL_CNT_EN: saturating per-job stall-cycle counter.
// Revision: 1.0
// ============================================================================
module main_stream_ctrl #(
  parameter int NLANES = 2,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNTW-1:0]   nitems,
  output logic              busy,
  output logic              done,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              k_ivalid,
  input  logic [NLANES-1:0] k_iready,
  input  logic [NLANES-1:0] k_ovalid,
  output logic              k_oready,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic              lane_err,
  output logic [CNTW-1:0]   stall_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] nitems_q, nitems_d;
  logic [CNTW-1:0] in_cnt_q, in_cnt_d;
  logic [CNTW-1:0] out_cnt_q, out_cnt_d;
  logic            lane_err_q, lane_err_d;

  logic w_all_ir, w_all_ov, w_active, w_in_open;
  logic w_in_beat, w_out_beat, w_skew, w_start_acc;

  assign w_all_ir    = &k_iready;
  assign w_all_ov    = &k_ovalid;
  assign w_active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign w_in_open   = (state_q == ST_RUN) && (in_cnt_q < nitems_q);
  assign w_start_acc = (state_q == ST_IDLE) && start;

  assign k_ivalid  = w_in_open & src_valid;
  assign src_ready = w_in_open & w_all_ir;
  assign snk_valid = w_active & w_all_ov;
  assign k_oready  = w_active & snk_ready;

  assign w_in_beat  = k_ivalid & w_all_ir;
  // The compare keeps out_cnt bounded even if lanes present extra vectors.
  assign w_out_beat = snk_valid & snk_ready & (out_cnt_q < nitems_q);

  // Lanes disagree when some, but not all, of them assert a flag.
  assign w_skew = ((|k_iready) & ~w_all_ir) | ((|k_ovalid) & ~w_all_ov);

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign lane_err = lane_err_q;

  always_comb begin
    state_d    = state_q;
    nitems_d   = nitems_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    lane_err_d = lane_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nitems_d   = nitems;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          lane_err_d = 1'b0;
          state_d    = (nitems == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (w_in_beat) in_cnt_d = in_cnt_q + CNT_ONE;
        if (w_out_beat) out_cnt_d = out_cnt_q + CNT_ONE;
        // Output completion wins: the last vector may leave while still in RUN.
        if (out_cnt_d == nitems_q) begin
          state_d = ST_DONE;
        end else if ((state_q == ST_RUN) && (in_cnt_q == nitems_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (busy && w_skew) lane_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      nitems_q   <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      lane_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nitems_q   <= nitems_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      lane_err_q <= lane_err_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            w_stall;

  assign w_stall = w_active & ((k_ivalid & ~w_all_ir) | (w_all_ov & ~snk_ready));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_start_acc) begin
      stall_cnt_d = '0;
    end else if (w_stall && (stall_cnt_q != {CNTW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic w_unused;
  assign w_unused  = w_start_acc;
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_stream_ctrl.sv
`default_nettype none
// tb_main_stream_ctrl : directed scenarios plus randomized traffic for main_stream_ctrl,
// checked against a job-level model (active/done flags and beat counts).
module tb_main_stream_ctrl;
  localparam int NLANES = 2;
  localparam int CNTW   = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CNTW-1:0]   nitems = '0;
  logic              busy, done;
  logic              src_valid = 1'b0;
  logic              src_ready, k_ivalid;
  logic [NLANES-1:0] k_iready = '0;
  logic [NLANES-1:0] k_ovalid = '0;
  logic              k_oready, snk_valid;
  logic              snk_ready = 1'b0;
  logic              lane_err;
  logic [CNTW-1:0]   stall_cnt;

  always #5 clk = ~clk;

  main_stream_ctrl #(.NLANES(NLANES), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .nitems(nitems), .busy(busy), .done(done),
    .src_valid(src_valid), .src_ready(src_ready), .k_ivalid(k_ivalid), .k_iready(k_iready),
    .k_ovalid(k_ovalid), .k_oready(k_oready), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .lane_err(lane_err), .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Job-level reference: a job is active until nitems vectors have left, then done for one cycle.
  bit              m_active = 1'b0, m_done = 1'b0, m_lerr = 1'b0;
  logic [CNTW-1:0] m_n = '0, m_in = '0, m_out = '0, m_stall = '0;

  function automatic bit mixed(input logic [NLANES-1:0] v);
    return (v != '0) && (v != '1);
  endfunction

  function automatic logic [CNTW-1:0] exp_stall();
`ifdef STALL_CNT_EN
    return m_stall;
`else
    return '0;
`endif
  endfunction

  function automatic logic [NLANES-1:0] pick_lanes();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 2'b01;
    if (r == 1) return 2'b10;
    if (r < 4) return 2'b00;
    return 2'b11;
  endfunction

  task automatic drive(input logic s, input logic [CNTW-1:0] n, input logic sv,
                       input logic [NLANES-1:0] ir, input logic [NLANES-1:0] ov, input logic sr);
    start = s; nitems = n; src_valid = sv; k_iready = ir; k_ovalid = ov; snk_ready = sr;
  endtask

  // Advances one clock and the model with the inputs currently applied.
  task automatic tick();
    bit a_ir, a_ov, kiv, was_busy, n_active, n_done, n_lerr;
    logic [CNTW-1:0] n_n, n_in, n_out, n_stall;
    a_ir = &k_iready; a_ov = &k_ovalid;
    was_busy = m_active | m_done;
    n_active = m_active; n_done = m_done; n_lerr = m_lerr;
    n_n = m_n; n_in = m_in; n_out = m_out; n_stall = m_stall;
    if (!rst) begin
      n_active = 0; n_done = 0; n_lerr = 0; n_in = '0; n_out = '0; n_stall = '0;
    end else if (m_done) begin
      n_done = 0;
    end else if (!m_active) begin
      if (start) begin
        n_n = nitems; n_in = '0; n_out = '0; n_lerr = 0; n_stall = '0;
        if (nitems == '0) n_done = 1; else n_active = 1;
      end
    end else begin
      kiv = (m_in < m_n) && src_valid;
      if (kiv && a_ir) n_in = m_in + 1;
      if (a_ov && snk_ready) n_out = m_out + 1;
      if (n_out == m_n) begin n_active = 0; n_done = 1; end
      if (((kiv && !a_ir) || (a_ov && !snk_ready)) && (m_stall != '1)) n_stall = m_stall + 1;
    end
    if (rst && was_busy && (mixed(k_ovalid) || mixed(k_iready))) n_lerr = 1;
    @(posedge clk); #1;
    m_active = n_active; m_done = n_done; m_lerr = n_lerr;
    m_n = n_n; m_in = n_in; m_out = n_out; m_stall = n_stall;
  endtask

  task automatic test_reset();
    #2; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom_range(0, 5), 1'b1, pick_lanes(), pick_lanes(), 1'b1);
      #1;
      checks++;
      if ({busy, done, src_ready, k_ivalid, k_oready, snk_valid, lane_err} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b want 0000000",
                 {busy, done, src_ready, k_ivalid, k_oready, snk_valid, lane_err});
      end
      checks++;
      if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
      tick();
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int ib = 0, ob = 0, last_out = -1, done_cyc = -1, ndone = 0, idle_cyc = -1, first_iv = -1;
    drive(1'b1, 4, 1'b1, 2'b11, 2'b11, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 20 && idle_cyc < 0; c++) begin
      #1;
      if (k_ivalid && first_iv < 0) first_iv = c;
      if (k_ivalid && src_ready) ib++;
      if (snk_valid && k_oready) begin ob++; last_out = c; end
      if (done) begin ndone++; done_cyc = c; end
      if (!busy) idle_cyc = c;
      tick();
    end
    checks++; if (first_iv !== 0) begin errors++; $display("FAIL basic_ivalid_latency: got %0d want 0", first_iv); end
    checks++; if (ib !== 4) begin errors++; $display("FAIL basic_in_beats: got %0d want 4", ib); end
    checks++; if (ob !== 4) begin errors++; $display("FAIL basic_out_beats: got %0d want 4", ob); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", ndone); end
    checks++; if (done_cyc !== last_out + 1) begin errors++; $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_out + 1); end
    checks++; if (idle_cyc !== done_cyc + 1) begin errors++; $display("FAIL basic_busy_drop: got %0d want %0d", idle_cyc, done_cyc + 1); end
  endtask

  task automatic test_zero();
    drive(1'b1, 0, 1'b1, 2'b11, 2'b11, 1'b1);
    tick();
    start = 1'b0;
    #1;
    checks++;
    if ({done, busy, k_ivalid, snk_valid} !== 4'b1100) begin
      errors++; $display("FAIL zero_done_cycle: got %b want 1100", {done, busy, k_ivalid, snk_valid});
    end
    tick(); #1;
    checks++;
    if ({done, busy, k_ivalid} !== 3'b000) begin
      errors++; $display("FAIL zero_after: got %b want 000", {done, busy, k_ivalid});
    end
  endtask

  task automatic test_lane_skew();
    int ib = 0; bit sr_seen = 0; bit seen_done = 0;
    drive(1'b1, 3, 1'b1, 2'b01, 2'b00, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (src_ready) sr_seen = 1;
      if (k_ivalid && src_ready) ib++;
      tick();
    end
    #1;
    checks++; if (sr_seen !== 1'b0) begin errors++; $display("FAIL skew_src_ready: got 1 want 0"); end
    checks++; if (ib !== 0) begin errors++; $display("FAIL skew_in_beats: got %0d want 0", ib); end
    checks++; if (lane_err !== 1'b1) begin errors++; $display("FAIL skew_lane_err: got %b want 1", lane_err); end
    k_iready = 2'b11; k_ovalid = 2'b11;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      #1;
      if (k_ivalid && src_ready) ib++;
      if (done) seen_done = 1;
      tick();
    end
    #1;
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL skew_done: got 0 want 1"); end
    checks++; if (ib !== 3) begin errors++; $display("FAIL skew_total_in: got %0d want 3", ib); end
    checks++; if (lane_err !== 1'b1) begin errors++; $display("FAIL skew_sticky: got %b want 1", lane_err); end
`ifdef STALL_CNT_EN
    checks++; if (stall_cnt < 5) begin errors++; $display("FAIL skew_stall_cnt: got %0d want >=5", stall_cnt); end
`else
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL skew_stall_cnt: got %0d want 0", stall_cnt); end
`endif
  endtask

  task automatic test_drain_stall();
    int ib = 0, ob = 0, ob_at_done = -1; bit bad = 0;
    drive(1'b1, 2, 1'b1, 2'b11, 2'b00, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (k_ivalid && src_ready) ib++;
      tick();
    end
    k_ovalid = 2'b11; snk_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done || !busy || k_oready || !snk_valid || k_ivalid) bad = 1;
      tick();
    end
    checks++; if (ib !== 2) begin errors++; $display("FAIL drain_in_beats: got %0d want 2", ib); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL drain_hold: got 1 want 0"); end
    snk_ready = 1'b1;
    for (int c = 0; c < 10 && ob_at_done < 0; c++) begin
      #1;
      if (done) ob_at_done = ob;
      if (snk_valid && k_oready) ob++;
      tick();
    end
    checks++; if (ob_at_done !== 2) begin errors++; $display("FAIL drain_done_after_out: got %0d want 2", ob_at_done); end
  endtask

  task automatic test_reset_midjob();
    int ib = 0, ib2 = 0, ndone = 0;
    drive(1'b1, 8, 1'b1, 2'b11, 2'b00, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (k_ivalid && src_ready) ib++;
      tick();
    end
    #1; rst = 1'b0; #1;
    checks++;
    if ({busy, done, src_ready, k_ivalid, k_oready, snk_valid, lane_err} !== 7'b0 || stall_cnt !== '0) begin
      errors++; $display("FAIL midrst_outputs: got %b/%0d want 0000000/0",
                         {busy, done, src_ready, k_ivalid, k_oready, snk_valid, lane_err}, stall_cnt);
    end
    checks++; if (ib !== 2) begin errors++; $display("FAIL midrst_in_beats: got %0d want 2", ib); end
    tick(); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst_no_done: got %b want 00", {busy, done}); end
    rst = 1'b1;
    drive(1'b1, 1, 1'b1, 2'b11, 2'b11, 1'b1);
    tick();
    start = 1'b0;
    for (int c = 0; c < 10 && ndone == 0; c++) begin
      #1;
      if (k_ivalid && src_ready) ib2++;
      if (done) ndone++;
      tick();
    end
    checks++; if (ndone !== 1 || ib2 !== 1) begin errors++; $display("FAIL midrst_restart: got done=%0d in=%0d want done=1 in=1", ndone, ib2); end
  endtask

  task automatic test_start_while_busy();
    int ib = 0, ndone = 0;
    drive(1'b1, 3, 1'b1, 2'b11, 2'b11, 1'b1);
    tick();
    nitems = 7;
    for (int c = 0; c < 20 && ndone == 0; c++) begin
      #1;
      if (k_ivalid && src_ready) ib++;
      if (done) begin ndone++; start = 1'b0; end
      tick();
    end
    #1;
    checks++; if (ib !== 3) begin errors++; $display("FAIL busy_start_in_beats: got %0d want 3", ib); end
    checks++; if (ndone !== 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_done: got done=%0d busy=%b want 1/0", ndone, busy); end
  endtask

  task automatic test_random();
    logic [5:0] got, exp;
    for (int c = 0; c < 800; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      nitems    = $urandom_range(0, 6);
      src_valid = ($urandom_range(0, 3) != 0);
      k_iready  = pick_lanes();
      k_ovalid  = pick_lanes();
      snk_ready = ($urandom_range(0, 3) != 0);
      #1;
      got = {busy, done, src_ready, k_ivalid, k_oready, snk_valid};
      exp = {m_active | m_done, m_done,
             m_active && (m_in < m_n) && (k_iready == '1),
             m_active && (m_in < m_n) && src_valid,
             m_active && snk_ready,
             m_active && (k_ovalid == '1)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rand_outputs cyc %0d: got %b want %b", c, got, exp); end
      checks++;
      if (lane_err !== m_lerr) begin errors++; $display("FAIL rand_lane_err cyc %0d: got %b want %b", c, lane_err, m_lerr); end
      checks++;
      if (stall_cnt !== exp_stall()) begin errors++; $display("FAIL rand_stall cyc %0d: got %0d want %0d", c, stall_cnt, exp_stall()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_lane_skew();
    test_drain_stall();
    test_reset_midjob();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/main_stream_ctrl.md
MAIN_STREAM_CTRL -- requirements
Module: main_stream_ctrl

Interface
REQ-001 Parameters SHALL be: NLANES, default 2, number of lockstep kernel lanes; CNTW, default 32, beat-counter width.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; every register is rising-edge triggered.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-004 Port start, input, 1 bit, SHALL be a job-start request, sampled in IDLE only.
REQ-005 Port nitems, input, CNTW bits, SHALL give the vector beats in the job, latched on an accepted start.
REQ-006 Port busy, output, 1 bit, SHALL be high in RUN, DRAIN and DONE.
REQ-007 Port done, output, 1 bit, SHALL be a one-cycle job-complete pulse.
REQ-008 Port src_valid, input, 1 bit, SHALL flag an upstream input vector available.
REQ-009 Port src_ready, output, 1 bit, SHALL signal that the kernel lanes accept the input vector.
REQ-010 Port k_ivalid, output, 1 bit, SHALL be the ivalid shared by all lanes.
REQ-011 Port k_iready, input, NLANES bits, SHALL carry per-lane iready.
REQ-012 Port k_ovalid, input, NLANES bits, SHALL carry per-lane ovalid.
REQ-013 Port k_oready, output, 1 bit, SHALL be the oready shared by all lanes.
REQ-014 Port snk_valid, output, 1 bit, SHALL flag a complete output vector to downstream.
REQ-015 Port snk_ready, input, 1 bit, SHALL be downstream ready.
REQ-016 Port lane_err, output, 1 bit, SHALL be a sticky lane-desynchronisation flag.
REQ-017 Port stall_cnt, output, CNTW bits, SHALL carry the job stall-cycle count.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE: start=1 SHALL latch nitems, clear in_cnt, out_cnt, lane_err and stall_cnt, then go to RUN, or to DONE if nitems=0.
REQ-020 start SHALL be ignored in RUN, DRAIN and DONE; nitems SHALL be sampled only on an accepted start.
REQ-021 all_ir SHALL be the AND of k_iready; all_ov SHALL be the AND of k_ovalid.
REQ-022 In RUN with in_cnt<nitems: k_ivalid=src_valid and src_ready=all_ir; otherwise k_ivalid=0 and src_ready=0, both combinational.
REQ-023 An input beat SHALL occur when k_ivalid=1 and all_ir=1; in_cnt SHALL then increment by 1.
REQ-024 RUN SHALL go to DRAIN on the cycle after in_cnt reaches nitems.
REQ-025 In RUN and DRAIN: snk_valid=all_ov and k_oready=snk_ready; in IDLE and DONE both SHALL be 0.
REQ-026 An output beat SHALL occur when snk_valid=1 and snk_ready=1; out_cnt SHALL then increment by 1.
REQ-027 When out_cnt reaches nitems, the FSM SHALL go to DONE from either RUN or DRAIN.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Counters SHALL never exceed nitems.
REQ-030 No wrap-around SHALL occur for any nitems up to 2^CNTW-1.
REQ-031 An input beat and an output beat in the same cycle SHALL both be counted.
REQ-032 lane_err SHALL set while busy whenever k_ovalid or k_iready is neither all-ones nor all-zeros.
REQ-033 lane_err SHALL hold until the next accepted start or reset.
REQ-034 Latency from accepted start to first possible k_ivalid SHALL be 1 cycle.

Reset
REQ-035 On rst=0, the FSM SHALL enter IDLE asynchronously and all counters SHALL clear.
REQ-036 During reset: busy=0, done=0, lane_err=0, stall_cnt=0, and every handshake output=0.
REQ-037 Reset asserted mid-job SHALL abort the job with no done pulse.
REQ-038 After reset releases, the block SHALL accept start on the first clock edge.

Configuration
REQ-039 With STALL_CNT_EN defined, stall_cnt SHALL increment each RUN/DRAIN cycle where (k_ivalid & ~all_ir) | (all_ov & ~snk_ready), saturating at all-ones.
REQ-040 Without STALL_CNT_EN, stall_cnt SHALL be constant 0 and no stall-counter register SHALL exist.

Verification
REQ-041 start, nitems=4, src_valid=1, k_iready=2'b11, k_ovalid=2'b11 constant, snk_ready=1 -> 4 input beats, 4 output beats, done pulse 1 cycle after the 4th output beat, busy drops the next cycle.
REQ-042 start with nitems=0 -> next cycle DONE, done=1 for 1 cycle, zero beats, k_ivalid never asserted.
REQ-043 nitems=3, k_iready=2'b01 for 5 cycles then 2'b11 -> no input beat and src_ready=0 during those 5 cycles, lane_err=1; with STALL_CNT_EN, stall_cnt>=5.
REQ-044 nitems=2, snk_ready=0 during DRAIN for 10 cycles -> FSM holds DRAIN, out_cnt stays below 2, done only after snk_ready returns.
REQ-045 rst pulled low mid-RUN with in_cnt=2 -> immediate IDLE, all outputs 0, no done; a new start with nitems=1 then completes normally.
REQ-046 start asserted while busy with nitems=7 -> ignored; the job completes with the originally latched count.
